// File: rtl/minibus_master_ctrl.sv
// rtl/minibus_master_ctrl.sv - single-outstanding minibus master for core load/store requests
//
// Purpose: accepts one core request at a time, checks its alignment, runs one
// minibus cycle with a wait/timeout, and returns an extended load result.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cpu_valid/ready core request handshake
//   cpu_addr/wen/width/signed/wdata  request fields (width 00 byte, 01 half, 10 word)
//   resp_valid/ready                  response handshake
//   resp_rdata/err/timeout            response payload
//   bus_sel/wen/ren/addr/width/wdata  minibus request outputs
//   bus_ack/err/rdata                 minibus slave response inputs
module minibus_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wen,
  input  logic [1:0]            cpu_width,
  input  logic                  cpu_signed,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic                  bus_sel,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [1:0]            bus_width,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [1:0]            r_width;
  logic                  r_signed;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_timeout;

  logic                  w_misaligned;
  logic                  w_bus_done;
  logic                  w_timeout_hit;
  logic [DATA_WIDTH-1:0] w_ext;

  // Width 11 is treated as a misaligned access so it is rejected without a bus cycle.
  always_comb begin
    w_misaligned = 1'b0;
    case (cpu_width)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = cpu_addr[0];
      2'b10:   w_misaligned = |cpu_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  assign w_bus_done    = bus_ack | bus_err;
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Load extension uses the latched width/sign, never the live core inputs.
  always_comb begin
    w_ext = bus_rdata;
    case (r_width)
      2'b00: w_ext = r_signed ? {{(DATA_WIDTH-8){bus_rdata[7]}}, bus_rdata[7:0]}
                              : {{(DATA_WIDTH-8){1'b0}}, bus_rdata[7:0]};
      2'b01: w_ext = r_signed ? {{(DATA_WIDTH-16){bus_rdata[15]}}, bus_rdata[15:0]}
                              : {{(DATA_WIDTH-16){1'b0}}, bus_rdata[15:0]};
      default: w_ext = bus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid) begin
          w_next = w_misaligned ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (w_bus_done || w_timeout_hit) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, wait counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_width   <= 2'b00;
      r_signed  <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_valid) begin
            r_addr    <= cpu_addr;
            r_wen     <= cpu_wen;
            r_width   <= cpu_width;
            r_signed  <= cpu_signed;
            r_wdata   <= cpu_wdata;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= w_misaligned;
            r_timeout <= 1'b0;
          end
        end
        S_REQ: begin
          if (w_bus_done) begin
            // bus_err wins over a simultaneous ack; errored or store responses carry no data.
            r_err     <= bus_err;
            r_timeout <= 1'b0;
            r_rdata   <= (bus_err || r_wen) ? '0 : w_ext;
          end else if (w_timeout_hit) begin
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    cpu_ready    = 1'b0;
    bus_sel      = 1'b0;
    bus_wen      = 1'b0;
    bus_ren      = 1'b0;
    resp_valid   = 1'b0;
    bus_addr     = r_addr;
    bus_width    = r_width;
    bus_wdata    = r_wdata;
    resp_rdata   = r_rdata;
    resp_err     = r_err;
    resp_timeout = r_timeout;
    case (r_state)
      S_IDLE: cpu_ready = 1'b1;
      S_REQ: begin
        bus_sel = 1'b1;
        bus_wen = r_wen;
        bus_ren = ~r_wen;
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minibus_master_ctrl.sv
// tb/tb_minibus_master_ctrl.sv - self-checking bench for minibus_master_ctrl
module tb_minibus_master_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [31:0] cpu_addr = '0;
  logic        cpu_wen = 1'b0;
  logic [1:0]  cpu_width = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic        bus_sel;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_addr;
  logic [1:0]  bus_width;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int failures = 0;

  minibus_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wen(cpu_wen), .cpu_width(cpu_width), .cpu_signed(cpu_signed),
    .cpu_wdata(cpu_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .bus_sel(bus_sel), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
    .bus_width(bus_width), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, alignment by modulo, extension by arithmetic.
  function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] width);
    longint size;
    if (width == 2'b11) return 1'b1;
    size = longint'(1) << width;
    return (longint'(addr) % size) != 0;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] rd, input logic [1:0] width,
                                          input bit sgn);
    longint bits;
    longint v;
    if (width == 2'b10) return rd;
    bits = (width == 2'b00) ? 8 : 16;
    v = longint'(rd) % (longint'(1) << bits);
    if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // One complete core transaction. The slave responds in sel cycle 'delay'
  // (0 = first sel cycle); delay >= TMO means it never responds.
  // mode: 0 ack only, 1 err only, 2 ack and err together.
  task automatic run_txn(input logic [31:0] addr, input bit wen, input logic [1:0] width,
                         input bit sgn, input logic [31:0] wdata, input int delay,
                         input int mode, input logic [31:0] rdata, input int hold);
    bit          mis;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rd;
    int          sel_cnt;
    int          exp_sel;
    @(negedge clk);
    chk("ready_idle", {31'd0, cpu_ready}, 32'd1);
    cpu_addr = addr; cpu_wen = wen; cpu_width = width; cpu_signed = sgn; cpu_wdata = wdata;
    cpu_valid = 1'b1;
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_addr = $urandom; cpu_wdata = $urandom;
    chk("ready_after_accept", {31'd0, cpu_ready}, 32'd0);
    mis = ref_misaligned(addr, width);
    if (mis) begin
      exp_err = 1'b1; exp_to = 1'b0; exp_rd = '0;
      chk("mis_no_sel", {31'd0, bus_sel}, 32'd0);
    end else begin
      sel_cnt = 0;
      while (bus_sel === 1'b1 && sel_cnt < 64) begin
        chk("bus_wen", {31'd0, bus_wen}, {31'd0, wen});
        chk("bus_ren", {31'd0, bus_ren}, {31'd0, ~wen});
        chk("bus_addr", bus_addr, addr);
        chk("bus_width", {30'd0, bus_width}, {30'd0, width});
        chk("bus_wdata", bus_wdata, wdata);
        if (sel_cnt == delay) begin
          bus_rdata = rdata;
          bus_ack = (mode != 1);
          bus_err = (mode != 0);
        end
        sel_cnt++;
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      end
      exp_sel = (delay < TMO) ? delay + 1 : TMO;
      chk("sel_cycles", 32'(sel_cnt), 32'(exp_sel));
      if (delay >= TMO) begin
        exp_err = 1'b1; exp_to = 1'b1; exp_rd = '0;
      end else if (mode != 0) begin
        exp_err = 1'b1; exp_to = 1'b0; exp_rd = '0;
      end else begin
        exp_err = 1'b0; exp_to = 1'b0; exp_rd = wen ? 32'd0 : ref_ext(rdata, width, sgn);
      end
    end
    for (int i = 0; i <= hold; i++) begin
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_sel_low", {29'd0, bus_sel, bus_wen, bus_ren}, 32'd0);
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, exp_to});
      chk("resp_rdata", resp_rdata, exp_rd);
      if (i == hold) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_ready", {31'd0, cpu_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rst_outputs", {27'd0, bus_sel, bus_wen, bus_ren, resp_valid, resp_err}, 32'd0);
    chk("rst_timeout", {31'd0, resp_timeout}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rst = 1'b0;

    // Word store with a 1-wait slave
    run_txn(32'h8, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 1, 0, 32'h12345678, 0);
    // Byte load, signed and unsigned
    run_txn(32'h5, 1'b0, 2'b00, 1'b1, 32'h0, 1, 0, 32'h00000080, 0);
    run_txn(32'h5, 1'b0, 2'b00, 1'b0, 32'h0, 1, 0, 32'h00000080, 0);
    // Half load
    run_txn(32'h6, 1'b0, 2'b01, 1'b1, 32'h0, 0, 0, 32'h1234_8001, 1);
    // Misaligned half and illegal width
    run_txn(32'h3, 1'b0, 2'b01, 1'b0, 32'h0, 0, 0, 32'h0, 0);
    run_txn(32'h4, 1'b0, 2'b11, 1'b0, 32'h0, 0, 0, 32'h0, 0);
    // Slave never responds
    run_txn(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 99, 0, 32'h0, 0);
    // Ack and err together, response held 3 cycles
    run_txn(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, 1, 2, 32'hCAFEF00D, 3);

    // Reset while in REQ
    @(negedge clk);
    cpu_addr = 32'h40; cpu_wen = 1'b0; cpu_width = 2'b10; cpu_valid = 1'b1;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_sel", {31'd0, bus_sel}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_sel", {31'd0, bus_sel}, 32'd0);
    chk("async_rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("async_rst_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_resp", {31'd0, resp_valid}, 32'd0);
    run_txn(32'h44, 1'b0, 2'b00, 1'b1, 32'h0, 2, 0, 32'h0000_00FE, 0);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [1:0]  w;
      int          d;
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && w != 2'b11) a = a & ~((32'd1 << w) - 32'd1);
      d = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      run_txn(a, 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), $urandom, d,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
              $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
